uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  Serial receive engine of the UART: recovers frames from the RX line and emits bytes to the RX FIFO.
//  Oversamples at 16x baud using the shared baud generator tick, with majority-vote bit sampling.
//  Checks optional parity and stop-bit framing, and reports error strobes to the top-level status register.
//  Sits between pin i_RX and the RX FIFO write port. It is the receive-side counterpart of the TX serializer.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame, LSB first
//  PARITY_EN   0  1 = one parity bit follows the data bits
// PORTS
//  i_clk         in   1           system clock
//  i_rst         in   1           asynchronous, active-high reset
//  i_tick_x16    in   1           1-cycle strobe at 16x baud, from the baud generator
//  i_parity_odd  in   1           1 = odd parity, 0 = even parity; ignored when PARITY_EN=0
//  i_RX          in   1           asynchronous serial input, idle high
//  o_data        out  DATA_WIDTH  last received byte; held until the next o_valid
//  o_valid       out  1           1-cycle strobe; drives the RX FIFO write
//  o_rx_error    out  2           1-cycle strobes, coincident with o_valid: [1] frame, [0] parity
//  o_busy        out  1           high in any state except IDLE
// BEHAVIOUR
//  Clocking and reset
//  - One clock domain. Reset is asynchronous and active-high.
//  - Reset values: o_data=0, o_valid=0, o_rx_error=0, o_busy=0, state=IDLE, sync flops=1.
//  - Reset asserted mid-frame abandons the frame with no strobe. After release the core waits in IDLE.
//  Input sampling
//  - i_RX passes through a 2-flop synchronizer (rx_s) before any use.
//  - The 4-bit tick counter cnt advances only on i_tick_x16 and wraps 15->0.
//  - Within each bit, samples are taken at cnt=7, 8 and 9.
//  - The bit value is the majority of those 3 samples, committed on the tick where cnt=9.
//  State machine
//  - IDLE: on rx_s==0, clear cnt and go to START.
//  - START: at the cnt=9 decision, a majority of 1 is a false start; return to IDLE with no strobe.
//    Otherwise continue. At cnt=15 go to DATA with bit index 0.
//  - DATA: shift each decided bit into a shift register, LSB first. After bit DATA_WIDTH-1 reaches cnt=15,
//    go to PARITY if PARITY_EN=1, else go to STOP.
//  - PARITY: at the cnt=9 decision, perr = bit ^ (^shreg) ^ i_parity_odd.
//    Expected parity bit is ^data ^ i_parity_odd. At cnt=15 go to STOP.
//  - STOP: at the cnt=9 decision, the following are registered in the same cycle:
//    o_data <= shreg, o_valid <= 1, o_rx_error <= {~bit, perr}.
//    Then go to IDLE if bit==1, else to BREAK.
//  - BREAK: stay until rx_s==1, then go to IDLE. This prevents a low or broken line from retriggering.
//  Latency and strobes
//  - o_valid rises 1 clk after the stop-bit cnt=9 tick, and lasts exactly 1 clk.
//  - Errored frames still assert o_valid. The top level decides whether to drop them.
//  - Leaving STOP at mid-bit lets a back-to-back start bit (zero idle) be detected on time.
//  - perr is forced to 0 when PARITY_EN=0.
//  - i_parity_odd is sampled only at the parity decision, so changing it mid-frame affects only that decision.
//  - No back-pressure exists. FIFO overrun accounting belongs to the top level.
// STRUCTURE
//  - uart_pkg holds typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP, BREAK} and the constants
//    OVERSAMPLE=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9.
//  - One sub-module, uart_rx_sync: 2-flop synchronizer with reset value 1, reused for any async input.
//  - The FSM, counters and shift register stay flat in this module.
// TESTING
//  - The bench generates i_tick_x16 every 13 clks (T_CLK=40) and a behavioural serial driver at 16 ticks/bit.
//  - Frame 0x55, PARITY_EN=0, stop=1 -> one o_valid, o_data=8'h55, o_rx_error=2'b00, o_busy then 0.
//  - Low glitch of 4 ticks on i_RX -> no o_valid, state returns to IDLE, o_busy=0 within 10 ticks.
//  - PARITY_EN=1, odd parity:
//    - 0x07 with parity bit 0 -> o_data=8'h07, o_rx_error=2'b00.
//    - 0x07 with parity bit 1 -> o_rx_error=2'b01.
//  - 0xA3 with stop bit 0, line held low 40 ticks, then high -> one o_valid with o_rx_error[1]=1.
//    No further o_valid until 1 tick after the line returns high plus a full new frame.
//  - Three back-to-back frames 0x00, 0xFF, 0x3C with zero idle -> three o_valid strobes, in that order, no errors.
//  - Single-clk pulse on one sample tick of a data bit (majority defeats it) -> byte is unchanged.
//  - i_rst asserted mid-DATA of 0x5A, then 0x81 sent after release -> only 0x81 emitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] SAMPLE_LO  = 4'd7;
  localparam logic [3:0] SAMPLE_MID = 4'd8;
  localparam logic [3:0] SAMPLE_HI  = 4'd9;
  localparam logic [3:0] CNT_LAST   = 4'(OVERSAMPLE - 1);

  // Two-out-of-three vote used to decide each received bit.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Receive-core signal bundle: line/tick inputs in, received byte and status out.
//
// Handshake: o_valid is a one-clock strobe with no ready; o_data and o_rx_error
// are meaningful on the strobe cycle, o_data then holds until the next strobe,
// and the consumer must accept every strobe because the core never stalls.
interface uart_rx_core_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
);

  logic                  i_tick_x16;
  logic                  i_parity_odd;
  logic                  i_RX;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic [1:0]            o_rx_error;
  logic                  o_busy;
  rx_state_t             state;

  modport slave (
    input  i_tick_x16, i_parity_odd, i_RX,
    output o_data, o_valid, o_rx_error, o_busy, state
  );

  modport master (
    output i_tick_x16, i_parity_odd, i_RX,
    input  o_data, o_valid, o_rx_error, o_busy, state
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Resets to 1 so an idle-high line never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: 16x oversampling, majority-vote bit decisions,
// optional parity, stop-bit framing check and break hold-off.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit PARITY_EN  = 1'b0
) (
  input logic           i_clk,
  input logic           i_rst,
  uart_rx_core_if.slave bus
);

  localparam int              IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  rx_state_t             state;
  logic                  rx_s;
  logic [3:0]            cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic                  s_lo;
  logic                  s_mid;
  logic                  bit_maj;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  perr;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic [1:0]            err_q;
  logic                  busy_q;

  uart_rx_sync u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (bus.i_RX),
    .q   (rx_s)
  );

  // Third sample is the live synchronized line on the cnt=9 tick.
  assign bit_maj = majority3(s_lo, s_mid, rx_s);

  // Frame state machine with counters, shift register and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      s_lo    <= 1'b1;
      s_mid   <= 1'b1;
      shreg   <= '0;
      perr    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 2'b00;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            cnt     <= '0;
            bit_idx <= '0;
            perr    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        BREAK: begin
          // Hold off until the line is released so a stuck-low line cannot retrigger.
          if (rx_s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          if (bus.i_tick_x16) begin
            cnt <= cnt + 4'd1;
            if (cnt == SAMPLE_LO)  s_lo  <= rx_s;
            if (cnt == SAMPLE_MID) s_mid <= rx_s;
            case (state)
              START: begin
                if (cnt == SAMPLE_HI && bit_maj) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                end else if (cnt == CNT_LAST) begin
                  state   <= DATA;
                  bit_idx <= '0;
                end
              end
              DATA: begin
                if (cnt == SAMPLE_HI) shreg <= {bit_maj, shreg[DATA_WIDTH-1:1]};
                if (cnt == CNT_LAST) begin
                  if (bit_idx == IDX_LAST) state <= PARITY_EN ? PARITY : STOP;
                  else                     bit_idx <= bit_idx + IDX_W'(1);
                end
              end
              PARITY: begin
                if (cnt == SAMPLE_HI) perr <= bit_maj ^ (^shreg) ^ bus.i_parity_odd;
                if (cnt == CNT_LAST) state <= STOP;
              end
              STOP: begin
                // Leave at mid-bit so a start bit with zero idle is caught on time.
                if (cnt == SAMPLE_HI) begin
                  data_q  <= shreg;
                  valid_q <= 1'b1;
                  err_q   <= {~bit_maj, perr & PARITY_EN};
                  busy_q  <= ~bit_maj;
                  state   <= bit_maj ? IDLE : BREAK;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.o_data     = data_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_rx_error = err_q;
  assign bus.o_busy     = busy_q;
  assign bus.state      = state;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: one instance without parity, one with odd parity.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int T_CLK    = 40;
  localparam int TICK_DIV = 13;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic tick = 1'b0;
  int   tcnt = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  logic       prev_v0 = 1'b0;
  logic       prev_v1 = 1'b0;

  uart_rx_core_if #(.DATA_WIDTH(8)) bus0 ();
  uart_rx_core_if #(.DATA_WIDTH(8)) bus1 ();

  uart_rx_core #(.DATA_WIDTH(8), .PARITY_EN(1'b0)) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0)
  );

  uart_rx_core #(.DATA_WIDTH(8), .PARITY_EN(1'b1)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1)
  );

  assign bus0.i_tick_x16 = tick;
  assign bus1.i_tick_x16 = tick;

  // Clock and 16x tick (one clk high every TICK_DIV clks, changed on the falling edge).
  always #(T_CLK/2) clk = ~clk;

  always @(negedge clk) begin
    tcnt = (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
    tick = (tcnt == 0);
  end

  // Scoreboard for the no-parity instance.
  always @(negedge clk) begin
    if (bus0.o_valid) begin
      n_checks++;
      if (prev_v0) begin
        n_fail++;
        $display("FAIL sb0_strobe_width: o_valid high 2+ clks, required 1 clk");
      end else if (exp_q0.size() == 0) begin
        n_fail++;
        $display("FAIL sb0_unexpected: got err=%b data=%h, required no strobe",
                 bus0.o_rx_error, bus0.o_data);
      end else begin
        logic [9:0] e;
        e = exp_q0.pop_front();
        if ({bus0.o_rx_error, bus0.o_data} !== e) begin
          n_fail++;
          $display("FAIL sb0_frame: got err=%b data=%h, required err=%b data=%h",
                   bus0.o_rx_error, bus0.o_data, e[9:8], e[7:0]);
        end
      end
    end
    prev_v0 = bus0.o_valid;
  end

  // Scoreboard for the odd-parity instance.
  always @(negedge clk) begin
    if (bus1.o_valid) begin
      n_checks++;
      if (prev_v1) begin
        n_fail++;
        $display("FAIL sb1_strobe_width: o_valid high 2+ clks, required 1 clk");
      end else if (exp_q1.size() == 0) begin
        n_fail++;
        $display("FAIL sb1_unexpected: got err=%b data=%h, required no strobe",
                 bus1.o_rx_error, bus1.o_data);
      end else begin
        logic [9:0] e;
        e = exp_q1.pop_front();
        if ({bus1.o_rx_error, bus1.o_data} !== e) begin
          n_fail++;
          $display("FAIL sb1_frame: got err=%b data=%h, required err=%b data=%h",
                   bus1.o_rx_error, bus1.o_data, e[9:8], e[7:0]);
        end
      end
    end
    prev_v1 = bus1.o_valid;
  end

  // Run-away guard.
  initial begin
    #(T_CLK * 100000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic wait_tick();
    do @(posedge clk); while (!tick);
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) bus1.i_RX = v;
    else     bus0.i_RX = v;
  endtask

  // One bit period; optionally a single-clk inversion landing on the cnt=8 sample.
  task automatic send_bit(input bit sel, input logic v, input bit glitch);
    @(negedge clk);
    set_rx(sel, v);
    if (glitch) begin
      repeat (8) wait_tick();
      repeat (10) @(posedge clk);
      @(negedge clk);
      set_rx(sel, ~v);
      @(negedge clk);
      set_rx(sel, v);
      repeat (8) wait_tick();
    end else begin
      repeat (16) wait_tick();
    end
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input logic par_bit, input logic stop_bit, input int glitch_idx);
    send_bit(sel, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i], glitch_idx == i);
    if (has_par) send_bit(sel, par_bit, 1'b0);
    send_bit(sel, stop_bit, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus0.o_data, bus0.o_valid, bus0.o_rx_error, bus0.o_busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs0: got data=%h valid=%b err=%b busy=%b, required all 0",
               bus0.o_data, bus0.o_valid, bus0.o_rx_error, bus0.o_busy);
    end
    n_checks++;
    if (bus0.state !== IDLE || bus1.state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d/%0d, required IDLE", bus0.state, bus1.state);
    end
    rst = 1'b0;
    repeat (2) wait_tick();
    n_checks++;
    if (bus0.o_busy !== 1'b0 || bus1.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b/%b, required 0/0", bus0.o_busy, bus1.o_busy);
    end
  endtask

  task automatic test_frame_55();
    exp_q0.push_back({2'b00, 8'h55});
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, -1);
    repeat (2) wait_tick();
    n_checks++;
    if (exp_q0.size() != 0) begin
      n_fail++;
      $display("FAIL frame55_missing: got %0d pending, required 0", exp_q0.size());
    end
    n_checks++;
    if (bus0.o_busy !== 1'b0 || bus0.o_data !== 8'h55) begin
      n_fail++;
      $display("FAIL frame55_hold: got busy=%b data=%h, required busy=0 data=55",
               bus0.o_busy, bus0.o_data);
    end
  endtask

  task automatic test_false_start();
    @(negedge clk);
    set_rx(1'b0, 1'b0);
    repeat (4) wait_tick();
    n_checks++;
    if (bus0.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_detect: got busy=%b, required 1", bus0.o_busy);
    end
    @(negedge clk);
    set_rx(1'b0, 1'b1);
    repeat (10) wait_tick();
    @(negedge clk);
    n_checks++;
    if (bus0.o_busy !== 1'b0 || bus0.state !== IDLE) begin
      n_fail++;
      $display("FAIL glitch_return: got busy=%b state=%0d, required busy=0 IDLE",
               bus0.o_busy, bus0.state);
    end
  endtask

  task automatic test_parity();
    logic [7:0] d;
    logic       good;
    d    = 8'h07;
    good = ~(^d);  // odd parity: total count of ones including the parity bit is odd
    for (int pb = 0; pb < 2; pb++) begin
      exp_q1.push_back({1'b0, (1'(pb) != good), d});
      send_frame(1'b1, d, 1'b1, 1'(pb), 1'b1, -1);
      repeat (2) wait_tick();
      n_checks++;
      if (exp_q1.size() != 0) begin
        n_fail++;
        $display("FAIL parity_missing pb=%0d: got %0d pending, required 0", pb, exp_q1.size());
      end
    end
  endtask

  task automatic test_break();
    exp_q0.push_back({2'b10, 8'hA3});
    send_frame(1'b0, 8'hA3, 1'b0, 1'b0, 1'b0, -1);
    repeat (40) wait_tick();
    @(negedge clk);
    n_checks++;
    if (bus0.state !== BREAK || bus0.o_busy !== 1'b1 || exp_q0.size() != 0) begin
      n_fail++;
      $display("FAIL break_hold: got state=%0d busy=%b pending=%0d, required BREAK busy=1 pending=0",
               bus0.state, bus0.o_busy, exp_q0.size());
    end
    set_rx(1'b0, 1'b1);
    wait_tick();
    @(negedge clk);
    n_checks++;
    if (bus0.state !== IDLE) begin
      n_fail++;
      $display("FAIL break_release: got state=%0d, required IDLE", bus0.state);
    end
    exp_q0.push_back({2'b00, 8'hC5});
    send_frame(1'b0, 8'hC5, 1'b0, 1'b0, 1'b1, -1);
    repeat (2) wait_tick();
    n_checks++;
    if (exp_q0.size() != 0) begin
      n_fail++;
      $display("FAIL break_next_frame: got %0d pending, required 0", exp_q0.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] tbl [3];
    tbl[0] = 8'h00;
    tbl[1] = 8'hFF;
    tbl[2] = 8'h3C;
    for (int i = 0; i < 3; i++) exp_q0.push_back({2'b00, tbl[i]});
    for (int i = 0; i < 3; i++) send_frame(1'b0, tbl[i], 1'b0, 1'b0, 1'b1, -1);
    repeat (2) wait_tick();
    n_checks++;
    if (exp_q0.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_missing: got %0d pending, required 0", exp_q0.size());
    end
  endtask

  task automatic test_sample_glitch();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    exp_q0.push_back({2'b00, d});
    send_frame(1'b0, d, 1'b0, 1'b0, 1'b1, int'($urandom_range(0, 7)));
    repeat (2) wait_tick();
    n_checks++;
    if (exp_q0.size() != 0) begin
      n_fail++;
      $display("FAIL sample_glitch_missing: got %0d pending, required 0", exp_q0.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'h5A;
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, d[i], 1'b0);
    @(negedge clk);
    rst = 1'b1;
    set_rx(1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (bus0.state !== IDLE || bus0.o_busy !== 1'b0 || bus0.o_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: got state=%0d busy=%b data=%h, required IDLE busy=0 data=00",
               bus0.state, bus0.o_busy, bus0.o_data);
    end
    repeat (20) @(negedge clk);
    rst = 1'b0;
    repeat (3) wait_tick();
    exp_q0.push_back({2'b00, 8'h81});
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, -1);
    repeat (2) wait_tick();
    n_checks++;
    if (exp_q0.size() != 0 || bus0.o_data !== 8'h81) begin
      n_fail++;
      $display("FAIL reset_resume: got pending=%0d data=%h, required 0 and 81",
               exp_q0.size(), bus0.o_data);
    end
  endtask

  initial begin
    bus0.i_RX         = 1'b1;
    bus1.i_RX         = 1'b1;
    bus0.i_parity_odd = 1'b0;
    bus1.i_parity_odd = 1'b1;
    test_reset();
    wait_tick();
    test_frame_55();
    test_false_start();
    wait_tick();
    test_parity();
    test_break();
    test_back_to_back();
    test_sample_glitch();
    test_reset_mid_frame();
    repeat (3) wait_tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
